// File: rtl/mmio_pkg.sv
// Region map for the MMIO controller: enum of address regions plus base/decode helpers.
// Everything is derived from the ROM/RAM depths and switch count so the map moves with the parameters.
package mmio_pkg;

    typedef enum logic [2:0] {
        RGN_ROM,
        RGN_RAM,
        RGN_SW,
        RGN_GPIO,
        RGN_STATUS,
        RGN_UNMAPPED
    } region_e;

    function automatic logic [63:0] sw_base(input logic [63:0] rom_depth,
                                            input logic [63:0] ram_depth);
        return rom_depth + ram_depth;
    endfunction

    function automatic logic [63:0] gpio_addr(input logic [63:0] rom_depth,
                                              input logic [63:0] ram_depth,
                                              input logic [63:0] n_sw);
        return sw_base(rom_depth, ram_depth) + n_sw;
    endfunction

    function automatic region_e decode(input logic [63:0] addr,
                                       input logic [63:0] rom_depth,
                                       input logic [63:0] ram_depth,
                                       input logic [63:0] n_sw);
        logic [63:0] swb;
        logic [63:0] gpa;
        region_e     rgn;
        swb = sw_base(rom_depth, ram_depth);
        gpa = gpio_addr(rom_depth, ram_depth, n_sw);
        if (addr < rom_depth)            rgn = RGN_ROM;
        else if (addr < swb)             rgn = RGN_RAM;
        else if (addr < gpa)             rgn = RGN_SW;
        else if (addr == gpa)            rgn = RGN_GPIO;
        else if (addr == gpa + 64'd1)    rgn = RGN_STATUS;
        else                             rgn = RGN_UNMAPPED;
        return rgn;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: SYNC_STAGES-flop synchroniser followed by a saturating-free debounce counter.
// sw_q follows the synced input after DEBOUNCE_CYC consecutive differing samples; changed is a same-cycle pulse.
module sw_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_q,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;

    assign synced  = sync[SYNC_STAGES-1];
    assign changed = (synced != sw_q) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            sw_q <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sw_raw};
            // Any sample matching the accepted value restarts the stability window.
            if (synced == sw_q) begin
                cnt <= '0;
            end else if (changed) begin
                sw_q <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_memory_controller.sv
// Load/store decoder for ROM, RAM, debounced switches, GPIO and W1C change status.
// Reads answer exactly one cycle later; a request is taken every cycle with no back-pressure.
module mmio_memory_controller
    import mmio_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 32,
    parameter int ROM_DEPTH    = 120000,
    parameter int RAM_DEPTH    = 121000,
    parameter int N_SW         = 21,
    parameter int GPIO_W       = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wd,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rd,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd,
    input  logic [N_SW-1:0]   sw_in,
    output logic [GPIO_W-1:0] gpio,
    output logic              gpio_stb,
    output logic              sw_irq
);

    localparam int SW_BASE = ROM_DEPTH + RAM_DEPTH;
    localparam int LOW_W   = (GPIO_W > N_SW) ? GPIO_W : N_SW;

    region_e          req_region;
    region_e          rsp_region;
    logic             rd_req;
    logic             wr_req;
    logic             sw_bit;
    logic [LOW_W-1:0] rd_low;
    logic [LOW_W-1:0] rsp_low;
    logic [N_SW-1:0]  sw_q;
    logic [N_SW-1:0]  sw_chg;
    logic [N_SW-1:0]  status;
    logic [N_SW-1:0]  w1c;

    assign req_region = decode(64'(req_addr), 64'(ROM_DEPTH), 64'(RAM_DEPTH), 64'(N_SW));
    assign rd_req     = req_valid && !req_we;
    assign wr_req     = req_valid && req_we;

    assign rom_addr = (req_region == RGN_ROM) ? req_addr : '0;
    assign ram_addr = (req_region == RGN_RAM) ? req_addr - ADDR_W'(ROM_DEPTH) : '0;
    assign ram_we   = wr_req && (req_region == RGN_RAM) && !rst;
    assign ram_wd   = req_wd;
    assign w1c      = (wr_req && req_region == RGN_STATUS) ? req_wd[N_SW-1:0] : '0;
    assign sw_irq   = |status;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sw_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (sw_in[i]),
            .sw_q   (sw_q[i]),
            .changed(sw_chg[i])
        );
    end

    always_comb begin
        sw_bit = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            if (req_addr == ADDR_W'(SW_BASE + i)) sw_bit = sw_q[i];
        end
    end

    // Register-backed regions are captured now; ROM/RAM data arrives from the memories next cycle.
    always_comb begin
        rd_low = '0;
        case (req_region)
            RGN_SW:     rd_low[0]          = sw_bit;
            RGN_GPIO:   rd_low[GPIO_W-1:0] = gpio;
            RGN_STATUS: rd_low[N_SW-1:0]   = status;
            default:    rd_low             = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_region <= RGN_UNMAPPED;
            rsp_low    <= '0;
            gpio       <= '0;
            gpio_stb   <= 1'b0;
            status     <= '0;
        end else begin
            rsp_valid  <= rd_req;
            rsp_err    <= req_valid && (req_we ? (req_region == RGN_ROM || req_region == RGN_SW ||
                                                  req_region == RGN_UNMAPPED)
                                               : (req_region == RGN_UNMAPPED));
            rsp_region <= req_region;
            rsp_low    <= rd_low;
            gpio_stb   <= wr_req && (req_region == RGN_GPIO);
            if (wr_req && req_region == RGN_GPIO) gpio <= req_wd[GPIO_W-1:0];
            // A new change sets its bit even when the same bit is being cleared.
            status <= (status & ~w1c) | sw_chg;
        end
    end

    always_comb begin
        rsp_rd = '0;
        if (rsp_valid) begin
            case (rsp_region)
                RGN_ROM: rsp_rd = rom_rd;
                RGN_RAM: rsp_rd = ram_rd;
                default: rsp_rd[LOW_W-1:0] = rsp_low;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_memory_controller.sv
// Bench for mmio_memory_controller: vector table, directed switch/reset sequences, random traffic vs reference model.
module tb_mmio_memory_controller;

    localparam int ROM_D  = 120000;
    localparam int RAM_D  = 121000;
    localparam int SW_B   = ROM_D + RAM_D;
    localparam int NSW    = 21;
    localparam int GPIO_A = SW_B + NSW;
    localparam int STAT_A = GPIO_A + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wd;
    logic         rsp_valid, rsp_err;
    logic [127:0] rsp_rd;
    logic [31:0]  rom_addr, ram_addr;
    logic [127:0] rom_rd, ram_rd, ram_wd;
    logic         ram_we;
    logic [20:0]  sw_in;
    logic [31:0]  gpio;
    logic         gpio_stb, sw_irq;

    mmio_memory_controller #(
        .DATA_W(128), .ADDR_W(32), .ROM_DEPTH(ROM_D), .RAM_DEPTH(RAM_D), .N_SW(NSW),
        .GPIO_W(32), .SYNC_STAGES(2), .DEBOUNCE_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wd(req_wd), .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wd(ram_wd), .ram_rd(ram_rd), .sw_in(sw_in), .gpio(gpio), .gpio_stb(gpio_stb),
        .sw_irq(sw_irq)
    );

    always #5 clk = ~clk;

    // External synchronous memories
    logic         fixed_mem = 1'b0;
    logic [127:0] ext_ram [int];

    function automatic logic [127:0] rom_word(input logic [31:0] a);
        return {4{a ^ 32'h1357_0000}};
    endfunction

    always @(posedge clk) begin
        rom_rd <= fixed_mem ? 128'hAA : rom_word(rom_addr);
        ram_rd <= fixed_mem ? 128'hBB : (ext_ram.exists(int'(ram_addr)) ? ext_ram[int'(ram_addr)] : '0);
        if (ram_we) ext_ram[int'(ram_addr)] = ram_wd;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [127:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wd    = wd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wd    = '0;
    endtask

    // Reference model state
    logic [31:0]  m_gpio;
    logic [20:0]  m_status;
    logic [20:0]  m_sw;
    logic [127:0] m_ram [int];

    task automatic model_step(input logic we, input logic [31:0] a, input logic [127:0] wd,
                              output logic ev, output logic ee, output logic [127:0] erd);
        longint x;
        x   = longint'(a);
        ev  = !we;
        ee  = 1'b0;
        erd = '0;
        if (x < ROM_D) begin
            if (we) ee = 1'b1; else erd = rom_word(a);
        end else if (x < SW_B) begin
            if (we) m_ram[int'(x - ROM_D)] = wd;
            else erd = m_ram.exists(int'(x - ROM_D)) ? m_ram[int'(x - ROM_D)] : '0;
        end else if (x < GPIO_A) begin
            if (we) ee = 1'b1; else erd = {127'd0, m_sw[int'(x - SW_B)]};
        end else if (x == GPIO_A) begin
            if (we) m_gpio = wd[31:0]; else erd = {96'd0, m_gpio};
        end else if (x == STAT_A) begin
            if (we) m_status = m_status & ~wd[20:0]; else erd = {107'd0, m_status};
        end else begin
            ee = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 6))
            0:       return 32'($urandom_range(0, ROM_D - 1));
            1, 2:    return 32'(ROM_D + 100 + $urandom_range(0, 15));
            3:       return 32'(SW_B + $urandom_range(0, NSW - 1));
            4:       return 32'(GPIO_A);
            5:       return 32'(STAT_A);
            default: return ($urandom_range(0, 1) == 0) ? 32'(STAT_A + 1 + $urandom_range(0, 500))
                                                         : $urandom() | 32'h8000_0000;
        endcase
    endfunction

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wd;
        logic         exp_valid;
        logic         exp_err;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic ev, ee;
        logic [127:0] erd;
        logic we;
        logic [31:0] a;
        logic [127:0] wd;

        tbl.push_back('{1'b0, 32'd0,          128'd0, 1'b1, 1'b0, rom_word(32'd0)});
        tbl.push_back('{1'b0, 32'd119999,     128'd0, 1'b1, 1'b0, rom_word(32'd119999)});
        tbl.push_back('{1'b1, 32'd120000,     128'h1111_2222, 1'b0, 1'b0, 128'd0});
        tbl.push_back('{1'b0, 32'd120000,     128'd0, 1'b1, 1'b0, 128'h1111_2222});
        tbl.push_back('{1'b1, 32'd240999,     {4{32'hCAFE_F00D}}, 1'b0, 1'b0, 128'd0});
        tbl.push_back('{1'b0, 32'd240999,     128'd0, 1'b1, 1'b0, {4{32'hCAFE_F00D}}});
        tbl.push_back('{1'b0, 32'd241000,     128'd0, 1'b1, 1'b0, 128'd0});
        tbl.push_back('{1'b0, 32'd241020,     128'd0, 1'b1, 1'b0, 128'd0});
        tbl.push_back('{1'b1, 32'd241020,     128'd1, 1'b0, 1'b1, 128'd0});
        tbl.push_back('{1'b1, 32'd241021,     128'h5_DEAD_BEEF, 1'b0, 1'b0, 128'd0});
        tbl.push_back('{1'b0, 32'd241021,     128'd0, 1'b1, 1'b0, 128'hDEAD_BEEF});
        tbl.push_back('{1'b0, 32'd241022,     128'd0, 1'b1, 1'b0, 128'd0});
        tbl.push_back('{1'b0, 32'd241023,     128'd0, 1'b1, 1'b1, 128'd0});
        tbl.push_back('{1'b0, 32'hFFFF_FFFF,  128'd0, 1'b1, 1'b1, 128'd0});
        tbl.push_back('{1'b1, 32'd119999,     128'd7, 1'b0, 1'b1, 128'd0});
        tbl.push_back('{1'b1, 32'd241023,     128'd7, 1'b0, 1'b1, 128'd0});

        rst = 1'b1;
        sw_in = '0;
        idle();
        repeat (3) step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_gpio", gpio, 0);
        chk("rst_gpio_stb", gpio_stb, 0);
        chk("rst_sw_irq", sw_irq, 0);
        chk("rst_ram_we", ram_we, 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            req(tbl[i].we, tbl[i].addr, tbl[i].wd);
            step();
            idle();
            chk($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_err", i), rsp_err, tbl[i].exp_err);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_rd", i), rsp_rd, tbl[i].exp_rd);
        end

        // Back-to-back ROM then RAM with fixed memory data
        fixed_mem = 1'b1;
        step();
        req(1'b0, 32'd5, 128'd0);
        #1 chk("b2b_rom_addr", rom_addr, 5);
        step();
        chk("b2b_rsp0_valid", rsp_valid, 1);
        chk("b2b_rsp0_rd", rsp_rd, 128'hAA);
        req(1'b0, 32'd120000, 128'd0);
        #1 chk("b2b_ram_addr", ram_addr, 0);
        chk("b2b_rom_addr_off", rom_addr, 0);
        step();
        idle();
        chk("b2b_rsp1_valid", rsp_valid, 1);
        chk("b2b_rsp1_rd", rsp_rd, 128'hBB);
        chk("b2b_rsp1_err", rsp_err, 0);
        fixed_mem = 1'b0;
        step();

        // GPIO write strobe
        req(1'b1, 32'(GPIO_A), 128'h1234);
        step();
        idle();
        chk("gpio_val", gpio, 32'h1234);
        chk("gpio_stb_hi", gpio_stb, 1);
        step();
        chk("gpio_stb_lo", gpio_stb, 0);
        req(1'b0, 32'(GPIO_A), 128'd0);
        step();
        idle();
        chk("gpio_rd", rsp_rd, 128'h1234);

        // Switch 3 debounce latency
        sw_in[3] = 1'b1;
        n = 0;
        while (!sw_irq && n < 40) begin
            step();
            n++;
        end
        chk("sw3_latency", 128'(n), 128'd18);
        repeat (12) step();
        req(1'b0, 32'(SW_B + 3), 128'd0);
        step();
        req(1'b0, 32'(STAT_A), 128'd0);
        chk("sw3_rd", rsp_rd, 128'd1);
        step();
        idle();
        chk("sw3_status", rsp_rd, 128'h8);

        // Short glitch on switch 0 is rejected
        sw_in[0] = 1'b1;
        repeat (5) step();
        sw_in[0] = 1'b0;
        repeat (25) step();
        req(1'b0, 32'(SW_B), 128'd0);
        step();
        req(1'b0, 32'(STAT_A), 128'd0);
        chk("glitch_sw0", rsp_rd, 128'd0);
        step();
        idle();
        chk("glitch_status", rsp_rd, 128'h8);

        // W1C racing a new change on the same bit: set wins
        req(1'b1, 32'(STAT_A), 128'h8);
        step();
        idle();
        chk("w1c_clear_irq", sw_irq, 0);
        sw_in[3] = 1'b0;
        repeat (17) step();
        req(1'b1, 32'(STAT_A), 128'h8);
        step();
        idle();
        chk("race_irq", sw_irq, 1);
        req(1'b0, 32'(STAT_A), 128'd0);
        step();
        req(1'b0, 32'(SW_B + 3), 128'd0);
        chk("race_status", rsp_rd, 128'h8);
        step();
        idle();
        chk("race_sw3", rsp_rd, 128'd0);
        req(1'b1, 32'(STAT_A), 128'h8);
        step();
        idle();
        chk("w1c_irq_fall", sw_irq, 0);

        // Unmapped read, ROM write, reset during a RAM read
        req(1'b0, 32'(STAT_A + 1), 128'd0);
        step();
        idle();
        chk("unm_valid", rsp_valid, 1);
        chk("unm_err", rsp_err, 1);
        chk("unm_rd", rsp_rd, 0);
        req(1'b1, 32'd10, 128'hFFFF);
        step();
        idle();
        chk("romw_valid", rsp_valid, 0);
        chk("romw_err", rsp_err, 1);
        step();
        chk("romw_err_pulse", rsp_err, 0);
        req(1'b0, 32'd10, 128'd0);
        step();
        idle();
        chk("romw_unchanged", rsp_rd, rom_word(32'd10));
        req(1'b0, 32'd120005, 128'd0);
        rst = 1'b1;
        step();
        idle();
        chk("rstrd_valid", rsp_valid, 0);
        chk("rstrd_err", rsp_err, 0);
        chk("rstrd_rd", rsp_rd, 0);
        chk("rstrd_gpio", gpio, 0);
        chk("rstrd_stb", gpio_stb, 0);
        chk("rstrd_irq", sw_irq, 0);
        chk("rstrd_ram_we", ram_we, 0);
        rst = 1'b0;
        step();

        // Random back-to-back traffic against the reference model
        sw_in = 21'h0A5A5;
        repeat (25) step();
        req(1'b1, 32'(STAT_A), 128'h1F_FFFF);
        step();
        idle();
        m_status = '0;
        m_sw     = 21'h0A5A5;
        m_gpio   = '0;
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = rand_addr();
            wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_step(we, a, wd, ev, ee, erd);
            req(we, a, wd);
            step();
            chk($sformatf("rnd%0d_valid", i), rsp_valid, ev);
            chk($sformatf("rnd%0d_err", i), rsp_err, ee);
            if (ev) chk($sformatf("rnd%0d_rd", i), rsp_rd, erd);
            chk($sformatf("rnd%0d_stb", i), gpio_stb, we && (a == 32'(GPIO_A)));
            chk($sformatf("rnd%0d_gpio", i), gpio, m_gpio);
            chk($sformatf("rnd%0d_irq", i), sw_irq, |m_status);
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
